// File: rtl/serial_shift_engine.sv
// Full-duplex serial shift engine: loads a word on start, shifts one bit per
// bit_strobe, counts its own bits and reports completion with a one-cycle done.
module serial_shift_engine #(
    parameter int   BITS       = 8,
    parameter int   COUNT_BITS = 4,
    parameter int   MSB_FIRST  = 0,
    parameter logic IDLE_OUT   = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [BITS-1:0] load_value,
    input  logic            bit_strobe,
    input  logic            in_bit,
    output logic            out_bit,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] data_out
);

    localparam logic [COUNT_BITS-1:0] LAST_CNT = COUNT_BITS'(BITS - 1);

    logic [BITS-1:0]       shreg;
    logic [BITS-1:0]       shreg_next;
    logic [COUNT_BITS-1:0] cnt;
    logic                  last_bit;

    always_comb begin
        shreg_next = shreg;
        if (MSB_FIRST != 0)
            shreg_next = {shreg[BITS-2:0], in_bit};
        else
            shreg_next = {in_bit, shreg[BITS-1:1]};
    end

    assign last_bit = (cnt == LAST_CNT);

    always_comb begin
        out_bit = IDLE_OUT;
        if (busy)
            out_bit = (MSB_FIRST != 0) ? shreg[BITS-1] : shreg[0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg    <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            data_out <= '0;
        end else begin
            done <= 1'b0;
            // abort wins over both a same-cycle start and a completing strobe
            if (abort) begin
                if (busy) begin
                    busy <= 1'b0;
                    cnt  <= '0;
                end
            end else if (start && !busy) begin
                shreg <= load_value;
                cnt   <= '0;
                busy  <= 1'b1;
            end else if (busy && bit_strobe) begin
                shreg <= shreg_next;
                if (last_bit) begin
                    // counter holds at its last value until the next start
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    data_out <= shreg_next;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_shift_engine.sv
// Directed bench: LSB-first and MSB-first 8-bit engines run side by side,
// plus a 16-bit LSB-first engine for the wide back-to-back case.
module tb_serial_shift_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        strobe = 1'b0;
    logic [7:0]  load8 = '0;
    logic [15:0] load16 = '0;
    logic        in_l = 1'b0, in_m = 1'b0, in16 = 1'b0;
    logic        out_l, out_m, out16;
    logic        busy_l, busy_m, busy16;
    logic        done_l, done_m, done16;
    logic [7:0]  data_l, data_m;
    logic [15:0] data16;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    serial_shift_engine #(.BITS(8), .COUNT_BITS(4), .MSB_FIRST(0), .IDLE_OUT(1'b1)) u_lsb (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .load_value(load8),
        .bit_strobe(strobe), .in_bit(in_l), .out_bit(out_l), .busy(busy_l),
        .done(done_l), .data_out(data_l));

    serial_shift_engine #(.BITS(8), .COUNT_BITS(4), .MSB_FIRST(1), .IDLE_OUT(1'b1)) u_msb (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .load_value(load8),
        .bit_strobe(strobe), .in_bit(in_m), .out_bit(out_m), .busy(busy_m),
        .done(done_m), .data_out(data_m));

    serial_shift_engine #(.BITS(16), .COUNT_BITS(4), .MSB_FIRST(0), .IDLE_OUT(1'b1)) u_w16 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .load_value(load16),
        .bit_strobe(strobe), .in_bit(in16), .out_bit(out16), .busy(busy16),
        .done(done16), .data_out(data16));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic b, input logic d, input logic [7:0] dat);
        chk({tag, "_busy_l"}, 16'(busy_l), 16'(b));
        chk({tag, "_busy_m"}, 16'(busy_m), 16'(b));
        chk({tag, "_done_l"}, 16'(done_l), 16'(d));
        chk({tag, "_done_m"}, 16'(done_m), 16'(d));
        chk({tag, "_data_l"}, 16'(data_l), 16'(dat));
        chk({tag, "_data_m"}, 16'(data_m), 16'(dat));
    endtask

    // Start a transfer of ld and issue n back-to-back strobes carrying rx,
    // checking each transmitted bit before its strobe.
    task automatic run8(input logic [7:0] ld, input logic [7:0] rx, input int n);
        load8 = ld;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run_busy", 16'(busy_l & busy_m), 16'd1);
        for (int i = 0; i < n; i++) begin
            chk("run_tx_l", 16'(out_l), 16'(ld[i]));
            chk("run_tx_m", 16'(out_m), 16'(ld[7-i]));
            in_l = rx[i];
            in_m = rx[7-i];
            strobe = 1'b1;
            tick();
        end
        strobe = 1'b0;
    endtask

    initial begin
        logic [7:0]  tx8;
        logic [7:0]  rx8;
        logic [15:0] tx16;
        logic [15:0] rx16;

        tick();
        chk8("reset", 1'b0, 1'b0, 8'h00);
        chk("reset_out_l", 16'(out_l), 16'd1);
        chk("reset_out_m", 16'(out_m), 16'd1);
        reset = 1'b0;
        tick();

        // Spaced strobes, with a start 0xFF while busy that must be ignored
        tx8 = 8'h12;
        rx8 = 8'hC3;
        load8 = tx8;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk8("start", 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            chk("spaced_tx_l", 16'(out_l), 16'(tx8[i]));
            chk("spaced_tx_m", 16'(out_m), 16'(tx8[7-i]));
            in_l = rx8[i];
            in_m = rx8[7-i];
            strobe = 1'b1;
            tick();
            strobe = 1'b0;
            if (i == 2) begin
                load8 = 8'hFF;
                start = 1'b1;
            end
            if (i < 7) begin
                chk8("spaced_mid", 1'b1, 1'b0, 8'h00);
                tick();
                start = 1'b0;
                tick();
                tick();
            end
        end
        chk8("spaced_done", 1'b0, 1'b1, 8'hC3);
        chk("spaced_idle_l", 16'(out_l), 16'd1);
        tick();
        chk8("spaced_after", 1'b0, 1'b0, 8'hC3);

        // Strobes while idle do nothing
        in_l = 1'b0;
        in_m = 1'b0;
        strobe = 1'b1;
        tick();
        tick();
        tick();
        strobe = 1'b0;
        chk8("idle_strobe", 1'b0, 1'b0, 8'hC3);
        chk("idle_out_l", 16'(out_l), 16'd1);
        chk("idle_out_m", 16'(out_m), 16'd1);

        // Asynchronous reset three strobes into a transfer
        run8(8'h12, 8'hC3, 3);
        chk8("pre_reset", 1'b1, 1'b0, 8'hC3);
        #2;
        reset = 1'b1;
        #1;
        chk8("async_reset", 1'b0, 1'b0, 8'h00);
        chk("async_out_l", 16'(out_l), 16'd1);
        chk("async_out_m", 16'(out_m), 16'd1);
        tick();
        reset = 1'b0;
        tick();
        run8(8'h12, 8'hC3, 8);
        chk8("post_reset_done", 1'b0, 1'b1, 8'hC3);
        tick();

        // Abort after 5 strobes
        run8(8'h12, 8'h0F, 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk8("abort5", 1'b0, 1'b0, 8'hC3);
        tick();
        chk8("abort5_after", 1'b0, 1'b0, 8'hC3);

        // Abort coinciding with the completing strobe
        run8(8'h12, 8'h0F, 7);
        in_l = 1'b1;
        in_m = 1'b1;
        strobe = 1'b1;
        abort = 1'b1;
        tick();
        strobe = 1'b0;
        abort = 1'b0;
        chk8("abort8", 1'b0, 1'b0, 8'hC3);
        tick();
        chk8("abort8_after", 1'b0, 1'b0, 8'hC3);

        // Abort and start together: nothing starts
        load8 = 8'h12;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk8("abort_start", 1'b0, 1'b0, 8'hC3);

        // Back-to-back: second start lands in the done cycle
        run8(8'h12, 8'hA5, 8);
        chk8("b2b_first", 1'b0, 1'b1, 8'hA5);
        run8(8'h5A, 8'h3C, 8);
        chk8("b2b_second", 1'b0, 1'b1, 8'h3C);
        tick();
        chk8("b2b_after", 1'b0, 1'b0, 8'h3C);

        // 16-bit engine, back-to-back
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("w16_reset", data16, 16'h0000);
        tx16 = 16'hBEEF;
        rx16 = 16'h1234;
        load16 = tx16;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("w16_tx1", 16'(out16), 16'(tx16[i]));
            in16 = rx16[i];
            strobe = 1'b1;
            tick();
        end
        strobe = 1'b0;
        chk("w16_done1", 16'(done16), 16'd1);
        chk("w16_busy1", 16'(busy16), 16'd0);
        chk("w16_data1", data16, 16'h1234);
        tx16 = 16'h5A5A;
        rx16 = 16'hF00D;
        load16 = tx16;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("w16_b2b_busy", 16'(busy16), 16'd1);
        chk("w16_b2b_done", 16'(done16), 16'd0);
        for (int i = 0; i < 16; i++) begin
            chk("w16_tx2", 16'(out16), 16'(tx16[i]));
            in16 = rx16[i];
            strobe = 1'b1;
            tick();
        end
        strobe = 1'b0;
        chk("w16_done2", 16'(done16), 16'd1);
        chk("w16_data2", data16, 16'hF00D);
        tick();
        chk("w16_after", 16'(done16), 16'd0);
        chk("w16_idle_out", 16'(out16), 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_shift_engine.md
# serial_shift_engine

Parametrised full-duplex serial shift engine with a built-in bit counter and a start/busy/done handshake. It is the successor to the plain loadable right shift register. Width, bit order and idle line level are parameters. The block also counts its own bits, supports abort, and captures the received word. Protocol front-ends (PSX controller port, future SPI-like links) instantiate it and supply a per-bit strobe from a shared clock divider.

## Interface
- BITS, 8, word width; must be ≥ 2
- COUNT_BITS, 4, bit-counter width; 2**COUNT_BITS ≥ BITS
- MSB_FIRST, 0, 0 = LSB transmitted/received first, 1 = MSB first
- IDLE_OUT, 1'b1, level driven on out_bit while not busy

- clk  in  1  system clock; all state on posedge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  begin a transfer; accepted only when busy=0
- abort  in  1  synchronous cancel of the current transfer
- load_value  in  BITS  word to transmit, sampled on the accepted start
- bit_strobe  in  1  one-cycle enable; one strobe = one bit time
- in_bit  in  1  serial receive data, sampled on bit_strobe
- out_bit  out  1  serial transmit data
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer completion
- data_out  out  BITS  last fully received word; held between completions

## Operation
- Internal state: shift register shreg[BITS], bit counter cnt[COUNT_BITS], busy, done, data_out.
- Idle (busy=0): out_bit = IDLE_OUT. bit_strobe and in_bit are ignored.
- Start accepted (start=1, busy=0, abort=0):
  - shreg <= load_value
  - cnt <= 0
  - busy <= 1
- start while busy=1 is ignored. It does not reload and does not restart.
- While busy, out_bit is combinational from registers:
  - shreg[0] when MSB_FIRST=0
  - shreg[BITS-1] when MSB_FIRST=1
- Each bit_strobe while busy shifts one bit:
  - LSB-first: shreg <= {in_bit, shreg[BITS-1:1]}
  - MSB-first: shreg <= {shreg[BITS-2:0], in_bit}
  - cnt <= cnt + 1
- Completion, on the strobe with cnt == BITS-1:
  - busy <= 0
  - done <= 1
  - data_out <= the post-shift shreg value
- done is forced to 0 on every cycle that is not a completion.
- Abort (abort=1): busy <= 0 and cnt <= 0. No done pulse; data_out is unchanged. Abort has priority over start and over a same-cycle completion strobe. Abort while idle has no effect.
- The counter never wraps: it is reset on every start and stops at completion.

## Timing
- Reset values: busy=0, done=0, data_out=0, shreg=0, cnt=0, out_bit=IDLE_OUT. Reset takes effect immediately and asynchronously, including mid-transfer.
- Start latency: busy=1 and the first tx bit appear on out_bit in the cycle after start is sampled.
- Each following tx bit appears in the cycle after the strobe that shifted out the previous one.
- in_bit is sampled on the same edge that advances out_bit. Front-ends place the strobe at their sample point.
- Completion: for the BITS-th strobe sampled at edge N, cycle N+1 shows busy=0, done=1 and the new data_out. In cycle N+2, done=0.
- Back-to-back: start asserted in the done cycle (N+1) is accepted, so busy=1 again at N+2. Transfers therefore need no idle gap.
- Strobes in consecutive cycles are legal. A transfer then takes BITS+1 cycles from start to done.

## Test plan
- Reset mid-transfer: assert reset after 3 strobes → busy=0, done=0, data_out=0 and out_bit=IDLE_OUT, all asynchronously. A start after reset release performs a full 8-bit transfer.
- LSB-first, BITS=8, load 0x12, in_bit driven LSB-first from 0xC3, strobe every 4 cycles → out_bit sequence 0,1,0,0,1,0,0,0. done pulses exactly one cycle, one cycle after the 8th strobe. data_out=0xC3.
- MSB-first, same stimulus with in_bit driven MSB-first from 0xC3 → out_bit sequence 0,0,0,1,0,0,1,0. data_out=0xC3.
- start while busy carrying load 0xFF → ignored; the transfer still transmits 0x12. Strobes while idle → out_bit stays 1, data_out unchanged.
- abort after 5 strobes, then abort coinciding with the 8th strobe → no done pulse in either case. data_out keeps its previous value (0xC3). busy=0 the next cycle. abort+start in the same cycle → transfer not started.
- Back-to-back: start in the done cycle with load 0x5A → busy=1 the next cycle. Second word completes correctly with continuous strobes in 9 cycles. Also repeat with BITS=16, COUNT_BITS=4.
